// File: rtl/vga_native_arb_if.sv
// Requester, response and native-port signals of vga_native_arb.
// The slave modport is the arbiter's view; master is the requester/native side.
interface vga_native_arb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req0_valid_i;
  logic              req0_we_i;
  logic [ADDR_W-1:0] req0_addr_i;
  logic [DATA_W-1:0] req0_wdata_i;
  logic              req0_ready_o;
  logic              rsp0_valid_o;
  logic [DATA_W-1:0] rsp0_rdata_o;
  logic              rsp0_ready_i;

  logic              req1_valid_i;
  logic              req1_we_i;
  logic [ADDR_W-1:0] req1_addr_i;
  logic [DATA_W-1:0] req1_wdata_i;
  logic              req1_ready_o;
  logic              rsp1_valid_o;
  logic [DATA_W-1:0] rsp1_rdata_o;
  logic              rsp1_ready_i;

  logic              write_en_o;
  logic [ADDR_W-1:0] addr_write_o;
  logic [DATA_W-1:0] data2native_o;
  logic              read_en_sync_o;
  logic [ADDR_W-1:0] addr_read_o;
  logic [DATA_W-1:0] data2axil_i;

  modport slave (
    input  req0_valid_i, req0_we_i, req0_addr_i, req0_wdata_i, rsp0_ready_i,
    input  req1_valid_i, req1_we_i, req1_addr_i, req1_wdata_i, rsp1_ready_i,
    input  data2axil_i,
    output req0_ready_o, rsp0_valid_o, rsp0_rdata_o,
    output req1_ready_o, rsp1_valid_o, rsp1_rdata_o,
    output write_en_o, addr_write_o, data2native_o, read_en_sync_o, addr_read_o
  );

  modport master (
    output req0_valid_i, req0_we_i, req0_addr_i, req0_wdata_i, rsp0_ready_i,
    output req1_valid_i, req1_we_i, req1_addr_i, req1_wdata_i, rsp1_ready_i,
    output data2axil_i,
    input  req0_ready_o, rsp0_valid_o, rsp0_rdata_o,
    input  req1_ready_o, rsp1_valid_o, rsp1_rdata_o,
    input  write_en_o, addr_write_o, data2native_o, read_en_sync_o, addr_read_o
  );
endinterface

// File: rtl/vga_native_arb.sv
// Two-requester arbiter onto a native register port, one transaction in flight.
// Define VGA_NATIVE_ARB_RR_EN for round-robin; otherwise requester 0 has fixed priority.
//
// state    | meaning
// StIdle   | no transaction; ready offered to the granted requester
// StWrite  | write_en_o pulse with latched addr/data
// StRead   | read_en_sync_o pulse with latched addr
// StRdWait | native read data valid, captured at end of cycle
// StResp   | response valid to owner until its rsp ready is seen
module vga_native_arb #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  vga_native_arb_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StRdWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              prio;
  logic              gnt1;
  logic              idle;
  logic              acc;
  logic              rsp_rdy;

`ifdef VGA_NATIVE_ARB_RR_EN
  logic prio_q, prio_d;

  // Pointer names the requester that wins the next contention.
  assign prio_d = acc ? ~gnt1 : prio_q;
  assign prio   = prio_q;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) prio_q <= 1'b0;
    else          prio_q <= prio_d;
  end
`else
  assign prio = 1'b0;
`endif

  assign idle = (state_q == StIdle);
  assign gnt1 = bus.req1_valid_i & (~bus.req0_valid_i | prio);

  // Ready is masked while reset is asserted so no accept is visible then.
  assign bus.req0_ready_o = idle & arst_ni & bus.req0_valid_i & ~gnt1;
  assign bus.req1_ready_o = idle & arst_ni & gnt1;
  assign acc              = bus.req0_ready_o | bus.req1_ready_o;
  assign rsp_rdy          = owner_q ? bus.rsp1_ready_i : bus.rsp0_ready_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (acc) begin
          owner_d = gnt1;
          we_d    = gnt1 ? bus.req1_we_i    : bus.req0_we_i;
          addr_d  = gnt1 ? bus.req1_addr_i  : bus.req0_addr_i;
          wdata_d = gnt1 ? bus.req1_wdata_i : bus.req0_wdata_i;
          rdata_d = '0;
          state_d = we_d ? StWrite : StRead;
        end
      end
      StWrite:  state_d = StResp;
      StRead:   state_d = StRdWait;
      StRdWait: begin
        rdata_d = bus.data2axil_i;
        state_d = StResp;
      end
      StResp:   if (rsp_rdy) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.write_en_o     = (state_q == StWrite);
  assign bus.read_en_sync_o = (state_q == StRead);
  assign bus.addr_write_o   = addr_q;
  assign bus.addr_read_o    = addr_q;
  assign bus.data2native_o  = wdata_q;

  assign bus.rsp0_valid_o = (state_q == StResp) & ~owner_q;
  assign bus.rsp1_valid_o = (state_q == StResp) & owner_q;
  assign bus.rsp0_rdata_o = bus.rsp0_valid_o ? rdata_q : '0;
  assign bus.rsp1_rdata_o = bus.rsp1_valid_o ? rdata_q : '0;

endmodule

// File: tb/tb_vga_native_arb.sv
// Bench for vga_native_arb: timeline model checked every cycle plus directed literal checks.
// Honours VGA_NATIVE_ARB_RR_EN the same way as the design.
module tb_vga_native_arb;

`ifdef VGA_NATIVE_ARB_RR_EN
  localparam bit RR = 1'b1;
  int exp_gnt [4] = '{0, 1, 0, 1};
`else
  localparam bit RR = 1'b0;
  int exp_gnt [4] = '{0, 0, 0, 0};
`endif

  logic clk_i = 1'b0;
  logic arst_ni;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk_i = ~clk_i;

  vga_native_arb_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  vga_native_arb #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .bus     (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic nxt();
    @(negedge clk_i);
  endtask

  // Model: a transaction accepted in cycle t_acc has its enable at t_acc+1 and
  // its response from t_acc+2 (write) or t_acc+3 (read) until the rsp ready is seen.
  int          cyc = 0;
  int          t_acc = 0;
  bit          busy = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_we = 1'b0;
  bit          last_gnt = 1'b1;
  logic [7:0]  last_addr = '0;
  logic [31:0] last_wdata = '0;
  logic [31:0] m_rdata = '0;
  int          gnt_log [$];

  initial begin : compare
    logic v0, v1, g1, e_r0, e_r1, e_wen, e_ren, rsp_on, e_v0, e_v1;
    int ph;
    forever begin
      @(negedge clk_i);
      #3;
      if (!arst_ni) begin
        busy = 1'b0; last_gnt = 1'b1; last_addr = '0; last_wdata = '0; m_rdata = '0;
      end
      v0     = bus.req0_valid_i;
      v1     = bus.req1_valid_i;
      g1     = v1 && (!v0 || (RR && !last_gnt));
      e_r0   = arst_ni && !busy && v0 && !g1;
      e_r1   = arst_ni && !busy && g1;
      ph     = cyc - t_acc;
      e_wen  = busy && m_we && ph == 1;
      e_ren  = busy && !m_we && ph == 1;
      rsp_on = busy && ph >= (m_we ? 2 : 3);
      e_v0   = rsp_on && !m_owner;
      e_v1   = rsp_on && m_owner;

      chk("ready0", 32'(bus.req0_ready_o), 32'(e_r0));
      chk("ready1", 32'(bus.req1_ready_o), 32'(e_r1));
      chk("write_en", 32'(bus.write_en_o), 32'(e_wen));
      chk("read_en", 32'(bus.read_en_sync_o), 32'(e_ren));
      chk("addr_write", 32'(bus.addr_write_o), 32'(last_addr));
      chk("addr_read", 32'(bus.addr_read_o), 32'(last_addr));
      chk("data2native", bus.data2native_o, last_wdata);
      chk("rsp0_valid", 32'(bus.rsp0_valid_o), 32'(e_v0));
      chk("rsp1_valid", 32'(bus.rsp1_valid_o), 32'(e_v1));
      chk("rsp0_rdata", bus.rsp0_rdata_o, e_v0 ? m_rdata : 32'h0);
      chk("rsp1_rdata", bus.rsp1_rdata_o, e_v1 ? m_rdata : 32'h0);

      if (bus.req0_valid_i && bus.req0_ready_o) gnt_log.push_back(0);
      if (bus.req1_valid_i && bus.req1_ready_o) gnt_log.push_back(1);

      if (arst_ni) begin
        if (busy && !m_we && ph == 2) m_rdata = bus.data2axil_i;
        if (rsp_on && (m_owner ? bus.rsp1_ready_i : bus.rsp0_ready_i)) begin
          busy = 1'b0;
        end else if (e_r0 || e_r1) begin
          busy       = 1'b1;
          t_acc      = cyc;
          m_owner    = e_r1;
          m_we       = e_r1 ? bus.req1_we_i : bus.req0_we_i;
          last_addr  = e_r1 ? bus.req1_addr_i : bus.req0_addr_i;
          last_wdata = e_r1 ? bus.req1_wdata_i : bus.req0_wdata_i;
          m_rdata    = '0;
          last_gnt   = e_r1;
        end
      end
      cyc++;
    end
  end

  initial begin : stim
    arst_ni          = 1'b0;
    bus.req0_valid_i = 1'b1;
    bus.req0_we_i    = 1'b0;
    bus.req0_addr_i  = '0;
    bus.req0_wdata_i = '0;
    bus.rsp0_ready_i = 1'b1;
    bus.req1_valid_i = 1'b0;
    bus.req1_we_i    = 1'b0;
    bus.req1_addr_i  = '0;
    bus.req1_wdata_i = '0;
    bus.rsp1_ready_i = 1'b1;
    bus.data2axil_i  = '0;

    // Reset: valid present but no ready, registers zero
    nxt(); #2;
    chk("rst_ready0", 32'(bus.req0_ready_o), 32'h0);
    chk("rst_addr", 32'(bus.addr_write_o), 32'h0);
    nxt(); bus.req0_valid_i = 1'b0;
    nxt(); arst_ni = 1'b1;
    nxt();
    nxt();

    // Requester 0 write 0x04 / 0xDEADBEEF
    nxt();
    bus.req0_valid_i = 1'b1; bus.req0_we_i = 1'b1;
    bus.req0_addr_i = 8'h04; bus.req0_wdata_i = 32'hDEADBEEF;
    #2 chk("wr_ready0", 32'(bus.req0_ready_o), 32'h1);
    nxt();
    bus.req0_valid_i = 1'b0; bus.req0_addr_i = 8'hFF; bus.req0_wdata_i = 32'h0;
    #2;
    chk("wr_en_pulse", 32'(bus.write_en_o), 32'h1);
    chk("wr_addr", 32'(bus.addr_write_o), 32'h04);
    chk("wr_data", bus.data2native_o, 32'hDEADBEEF);
    nxt(); #2;
    chk("wr_rsp0_valid", 32'(bus.rsp0_valid_o), 32'h1);
    chk("wr_rsp0_rdata", bus.rsp0_rdata_o, 32'h0);
    chk("wr_en_off", 32'(bus.write_en_o), 32'h0);
    nxt(); #2;
    chk("wr_rsp0_done", 32'(bus.rsp0_valid_o), 32'h0);

    // Requester 1 read 0x08, native data 0x12345678 two cycles after accept
    nxt();
    bus.req1_valid_i = 1'b1; bus.req1_we_i = 1'b0; bus.req1_addr_i = 8'h08;
    bus.data2axil_i = 32'hBAD0BAD0;
    #2 chk("rd_ready1", 32'(bus.req1_ready_o), 32'h1);
    nxt();
    bus.req1_valid_i = 1'b0;
    #2;
    chk("rd_en_pulse", 32'(bus.read_en_sync_o), 32'h1);
    chk("rd_addr", 32'(bus.addr_read_o), 32'h08);
    nxt();
    bus.data2axil_i = 32'h12345678;
    #2 chk("rd_en_off", 32'(bus.read_en_sync_o), 32'h0);
    nxt();
    bus.data2axil_i = 32'hBAD0BAD0;
    #2;
    chk("rd_rsp1_valid", 32'(bus.rsp1_valid_o), 32'h1);
    chk("rd_rsp1_rdata", bus.rsp1_rdata_o, 32'h12345678);
    nxt();

    // Contention: both valid for 10 cycles, four write accepts
    gnt_log.delete();
    nxt();
    bus.req0_valid_i = 1'b1; bus.req0_we_i = 1'b1; bus.req0_addr_i = 8'h0C; bus.req0_wdata_i = 32'hA0A0A0A0;
    bus.req1_valid_i = 1'b1; bus.req1_we_i = 1'b1; bus.req1_addr_i = 8'h1C; bus.req1_wdata_i = 32'hB1B1B1B1;
    repeat (9) nxt();
    nxt();
    bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
    repeat (3) nxt();
    chk("gnt_count", 32'(gnt_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_log.size()) chk("gnt_order", 32'(gnt_log[i]), 32'(exp_gnt[i]));
    end

    // Response back-pressure: rsp0 ready low 5 cycles, requester 1 waits
    nxt();
    bus.req0_valid_i = 1'b1; bus.req0_we_i = 1'b0; bus.req0_addr_i = 8'h10;
    bus.rsp0_ready_i = 1'b0;
    #2 chk("bp_ready0", 32'(bus.req0_ready_o), 32'h1);
    nxt();
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b1; bus.req1_we_i = 1'b1; bus.req1_addr_i = 8'h20; bus.req1_wdata_i = 32'h55AA55AA;
    #2 chk("bp_ready1_busy", 32'(bus.req1_ready_o), 32'h0);
    nxt();
    bus.data2axil_i = 32'hCAFEF00D;
    nxt();
    bus.data2axil_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("bp_rsp0_valid", 32'(bus.rsp0_valid_o), 32'h1);
      chk("bp_rsp0_rdata", bus.rsp0_rdata_o, 32'hCAFEF00D);
      chk("bp_no_accept", 32'(bus.req1_ready_o), 32'h0);
      nxt();
    end
    bus.rsp0_ready_i = 1'b1;
    #2 chk("bp_rsp0_hold", 32'(bus.rsp0_valid_o), 32'h1);
    nxt(); #2;
    chk("bp_rsp0_done", 32'(bus.rsp0_valid_o), 32'h0);
    chk("bp_ready1_idle", 32'(bus.req1_ready_o), 32'h1);
    nxt();
    bus.req1_valid_i = 1'b0;
    #2;
    chk("bp_wr_en", 32'(bus.write_en_o), 32'h1);
    chk("bp_wr_addr", 32'(bus.addr_write_o), 32'h20);
    nxt();
    nxt();

    // Reset during StRead aborts the read; requester 0 wins afterwards
    nxt();
    bus.req1_valid_i = 1'b1; bus.req1_we_i = 1'b0; bus.req1_addr_i = 8'h30;
    #2 chk("ra_ready1", 32'(bus.req1_ready_o), 32'h1);
    nxt();
    bus.req1_valid_i = 1'b0;
    #2 chk("ra_rd_en", 32'(bus.read_en_sync_o), 32'h1);
    arst_ni = 1'b0;
    #2;
    chk("ra_rd_en_clr", 32'(bus.read_en_sync_o), 32'h0);
    chk("ra_addr_clr", 32'(bus.addr_read_o), 32'h0);
    chk("ra_data_clr", bus.data2native_o, 32'h0);
    chk("ra_rsp1_clr", 32'(bus.rsp1_valid_o), 32'h0);
    nxt();
    nxt();
    arst_ni = 1'b1;
    repeat (5) nxt();
    nxt();
    bus.req0_valid_i = 1'b1; bus.req0_we_i = 1'b1; bus.req0_addr_i = 8'h40; bus.req0_wdata_i = 32'h11111111;
    bus.req1_valid_i = 1'b1; bus.req1_we_i = 1'b1; bus.req1_addr_i = 8'h50; bus.req1_wdata_i = 32'h22222222;
    #2;
    chk("ra_ready0", 32'(bus.req0_ready_o), 32'h1);
    chk("ra_ready1", 32'(bus.req1_ready_o), 32'h0);
    nxt();
    bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
    #2;
    chk("ra_wr_en", 32'(bus.write_en_o), 32'h1);
    chk("ra_wr_addr", 32'(bus.addr_write_o), 32'h40);
    chk("ra_wr_data", bus.data2native_o, 32'h11111111);
    repeat (3) nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
